// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mul_seq_pkg;

  // Default operand width; hi and lo are each this wide.
  localparam int unsigned MUL_WIDTH = 32;

  // Multiplier control states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    NEG  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage : mul_seq_pkg

// File: rtl/mul_seq_add_w.sv
// WIDTH-bit adder with carry-out, used for the shift-add accumulate step.
module add_w
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  // Full-width add; the extra top bit is the carry-out.
  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
  end

endmodule : add_w

// File: rtl/mul_seq.sv
// Sequential multiplier: one shift-add iteration per clock over WIDTH
// cycles, with an optional two's-complement fix-up cycle for signed
// operands whose product is negative.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               sign_q, sign_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;

  // Operand magnitudes for signed mode; the most negative value maps to
  // 2^(WIDTH-1) as an unsigned magnitude, which is exactly what we need.
  always_comb begin
    a_mag = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // Multiplicand is added only when the current multiplier LSB is set.
  always_comb begin
    addend = mplier_q[0] ? mcand_q : '0;
  end

  add_w #(
    .WIDTH (WIDTH)
  ) u_add (
    .a_i    (acc_q[ACC_W-1:WIDTH]),
    .b_i    (addend),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // Next-state logic for control and datapath registers.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d  = CALC;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          sign_d   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH - 1);
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // The adder carry-out lands in the top bit after the right shift.
          acc_d    = {cout, sum, acc_q[WIDTH-1:1]};
          mplier_d = mplier_q >> 1;
          if (cnt_q == '0) begin
            state_d = sign_q ? NEG : DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      NEG: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d   = ~acc_q + ACC_W'(1);
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Results are published only on entry to DONE, from the value the
    // accumulator takes on that same edge.
    if (state_d == DONE) begin
      hi_d = acc_d[ACC_W-1:WIDTH];
      lo_d = acc_d[WIDTH-1:0];
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Status outputs decoded directly from the current state.
  always_comb begin
    ready = (state_q == IDLE) || (state_q == DONE);
    busy  = (state_q == CALC) || (state_q == NEG);
    done  = (state_q == DONE);
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule : mul_seq

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases plus random
// operands checked against a plain-arithmetic product model.
module tb_mul_seq;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         abort;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_assert;
  int n_fail;
  int cyc;

  mul_seq #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_signed (op_signed),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from ordinary 64-bit arithmetic.
  function automatic logic [63:0] model_prod(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic s);
    longint px;
    longint py;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
      return 64'(px * py);
    end
    return {32'h0, x} * {32'h0, y};
  endfunction

  // Expected cycles from accept edge to done: one extra when signs differ.
  function automatic int model_lat(input logic [31:0] x,
                                   input logic [31:0] y,
                                   input logic s);
    return 32 + ((s && (x[31] ^ y[31])) ? 1 : 0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic do_start(input logic [31:0] x, input logic [31:0] y,
                          input logic s);
    start     = 1'b1;
    a         = x;
    b         = y;
    op_signed = s;
    @(posedge clk);
    #1;
    start     = 1'b0;
    a         = $urandom;
    b         = $urandom;
    op_signed = $urandom_range(0, 1);
    cyc       = 0;
  endtask

  task automatic finish_check(input logic [31:0] x, input logic [31:0] y,
                              input logic s, input string tag);
    logic [63:0] p;
    while (!done && cyc < 45) step();
    p = model_prod(x, y, s);
    chk({tag, "_lat"}, 64'(cyc), 64'(model_lat(x, y, s)));
    chk({tag, "_prod"}, {hi, lo}, p);
  endtask

  task automatic run_check(input logic [31:0] x, input logic [31:0] y,
                           input logic s, input string tag);
    do_start(x, y, s);
    finish_check(x, y, s, tag);
  endtask

  initial begin
    logic [63:0] prior;
    logic [31:0] rx, ry;
    logic        rs;
    int          seen;

    n_assert  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op_signed = 1'b0;
    a         = '0;
    b         = '0;
    abort     = 1'b0;

    // Reset values.
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned 7*6.
    run_check(32'd7, 32'd6, 1'b0, "u7x6");
    chk("u7x6_const", {hi, lo}, 64'h0000_0000_0000_002A);
    step();
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_ready", 64'(ready), 64'd1);

    // Unsigned all-ones: relies on carry retention.
    run_check(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax");
    chk("umax_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    step();

    // Signed -3*5 through NEG, and -4*-4 without it.
    run_check(32'hFFFF_FFFD, 32'd5, 1'b1, "sm3x5");
    chk("sm3x5_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("sm3x5_lat33", 64'(cyc), 64'd33);
    step();
    run_check(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, "sm4xm4");
    chk("sm4xm4_const", {hi, lo}, 64'h0000_0000_0000_0010);
    step();

    // Most negative squared.
    run_check(32'h8000_0000, 32'h8000_0000, 1'b1, "smin");
    chk("smin_const", {hi, lo}, 64'h4000_0000_0000_0000);
    step();

    // Start while busy is ignored.
    do_start(32'd1000, 32'd3, 1'b0);
    repeat (5) step();
    chk("busy_mid", 64'(busy), 64'd1);
    chk("ready_mid", 64'(ready), 64'd0);
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd9;
    step();
    start = 1'b0;
    finish_check(32'd1000, 32'd3, 1'b0, "ign_start");
    step();

    // Abort after 10 CALC iterations.
    prior = {hi, lo};
    do_start(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (10) step();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, prior);
    seen = 0;
    repeat (40) begin
      step();
      if (done) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_hilo_hold", {hi, lo}, prior);

    // Abort wins over start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    a     = 32'd2;
    b     = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_win_busy", 64'(busy), 64'd0);
    @(negedge clk);

    // Back-to-back: start issued in the DONE cycle.
    run_check(32'd123456, 32'd654321, 1'b0, "b2b_first");
    prior = {hi, lo};
    do_start(32'hFFFF_FF00, 32'd77, 1'b1);
    repeat (10) step();
    chk("b2b_hold", {hi, lo}, prior);
    finish_check(32'hFFFF_FF00, 32'd77, 1'b1, "b2b_second");
    step();

    // Asynchronous reset mid-CALC.
    do_start(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    repeat (8) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random operands, mixing idle gaps and back-to-back issue.
    for (int i = 0; i < 24; i++) begin
      rx = $urandom;
      ry = $urandom;
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rx = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) ry = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
      run_check(rx, ry, rs, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) != 0) begin
        step();
        chk($sformatf("rand%0d_pulse", i), 64'(done), 64'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mul_seq
